// File: rtl/sprite_addr_calc_if.sv
// Raster-position and sprite-descriptor bundle feeding one sprite address
// generator, plus the registered address/valid it returns.
interface sprite_addr_calc_if;
   logic [79:0] pattern_info;
   logic [31:0] sprite_info;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic [15:0] addr_output;
   logic        valid;

   modport master (
      output pattern_info,
      output sprite_info,
      output hcount,
      output vcount,
      input  addr_output,
      input  valid
   );

   modport slave (
      input  pattern_info,
      input  sprite_info,
      input  hcount,
      input  vcount,
      output addr_output,
      output valid
   );
endinterface

// File: rtl/sprite_addr_calc.sv
// Per-sprite pixel address generator: hit test, power-of-two tiling,
// horizontal flip and linear address, registered with one cycle of latency.
module sprite_addr_calc (
   input  logic              clk,
   input  logic              reset,
   sprite_addr_calc_if.slave bus
);

   logic        [15:0] base;
   logic        [15:0] res_h;
   logic        [15:0] res_v;
   logic        [15:0] act_h;
   logic        [15:0] act_v;
   logic               visible;
   logic               hflip;
   logic        [9:0]  pos_x;
   logic        [9:0]  pos_y;

   logic        [16:0] dx;
   logic        [16:0] dy;
   logic        [16:0] x_end;
   logic        [16:0] y_end;
   logic               in_h;
   logic               in_v;
   logic               sizes_ok;
   logic               hit;

   logic        [15:0] sx_tiled;
   logic        [15:0] sx;
   logic        [15:0] sy;
   logic        [31:0] row_offset;
   logic        [31:0] addr_wide;

   logic               valid_d;
   logic               valid_q;
   logic        [15:0] addr_d;
   logic        [15:0] addr_q;

   logic               unused_bits;

   // True when pos lies in [start, end); end is carried at 17 bits so a
   // rectangle running past column/row 1023 clips instead of wrapping.
   function automatic logic in_span(input logic [9:0]  pos,
                                    input logic [9:0]  start,
                                    input logic [16:0] span_end);
      in_span = ({7'd0, pos} >= {7'd0, start}) && ({7'd0, pos} < span_end);
   endfunction

   function automatic logic [15:0] tile(input logic [15:0] offset,
                                        input logic [15:0] res);
      tile = offset & (res - 16'd1);
   endfunction

   function automatic logic [15:0] mirror(input logic [15:0] s,
                                          input logic [15:0] res,
                                          input logic        en);
      mirror = en ? (res - 16'd1 - s) : s;
   endfunction

   assign base    = bus.pattern_info[79:64];
   assign res_h   = bus.pattern_info[63:48];
   assign res_v   = bus.pattern_info[47:32];
   assign act_h   = bus.pattern_info[31:16];
   assign act_v   = bus.pattern_info[15:0];
   assign visible = bus.sprite_info[31];
   assign hflip   = bus.sprite_info[30];
   assign pos_x   = bus.sprite_info[29:20];
   assign pos_y   = bus.sprite_info[19:10];

   assign dx    = {7'd0, bus.hcount} - {7'd0, pos_x};
   assign dy    = {7'd0, bus.vcount} - {7'd0, pos_y};
   assign x_end = {7'd0, pos_x} + {1'b0, act_h};
   assign y_end = {7'd0, pos_y} + {1'b0, act_v};

   assign in_h     = in_span(bus.hcount, pos_x, x_end);
   assign in_v     = in_span(bus.vcount, pos_y, y_end);
   assign sizes_ok = (act_h != 16'd0) && (act_v != 16'd0) &&
                     (res_h != 16'd0) && (res_v != 16'd0);
   assign hit      = visible && sizes_ok && in_h && in_v;

   // Flip is applied to the tiled column so every repeated tile mirrors.
   assign sx_tiled   = tile(dx[15:0], res_h);
   assign sx         = mirror(sx_tiled, res_h, hflip);
   assign sy         = tile(dy[15:0], res_v);
   assign row_offset = sy * res_h;
   assign addr_wide  = {16'd0, base} + row_offset + {16'd0, sx};

   always_comb begin
      valid_d = 1'b0;
      addr_d  = 16'd0;
      if (hit) begin
         valid_d = 1'b1;
         addr_d  = addr_wide[15:0];
      end
   end

   // Output register: the only state in the block.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         addr_q  <= 16'd0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

   assign bus.valid       = valid_q;
   assign bus.addr_output = addr_q;

   assign unused_bits = ^{bus.sprite_info[9:0], dx[16], dy[16], addr_wide[31:16]};

endmodule

// File: tb/tb_sprite_addr_calc.sv
// Directed corners plus randomized descriptors for sprite_addr_calc, checked
// against an arithmetic reference model of the hit/tile/flip/address rules.
module tb_sprite_addr_calc;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sprite_addr_calc_if bus ();

   sprite_addr_calc dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   function automatic void model(input  logic [79:0] p,
                                 input  logic [31:0] s,
                                 input  logic [9:0]  h,
                                 input  logic [9:0]  v,
                                 input  logic        rst,
                                 output logic        ev,
                                 output logic [15:0] ea);
      longint b, rh, rv, ah, av, xx, yy, hh, vv, sx, sy, a;
      b  = p[79:64];
      rh = p[63:48];
      rv = p[47:32];
      ah = p[31:16];
      av = p[15:0];
      xx = s[29:20];
      yy = s[19:10];
      hh = h;
      vv = v;
      ev = 1'b0;
      ea = 16'd0;
      if (rst) return;
      if (s[31] && rh != 0 && rv != 0 && ah != 0 && av != 0 &&
          hh >= xx && hh < xx + ah && vv >= yy && vv < yy + av) begin
         sx = (hh - xx) % rh;
         sy = (vv - yy) % rv;
         if (s[30]) sx = rh - 1 - sx;
         a  = (b + sy * rh + sx) % 65536;
         ev = 1'b1;
         ea = a[15:0];
      end
   endfunction

   task automatic set_cfg(input logic [15:0] b, input logic [15:0] rh,
                          input logic [15:0] rv, input logic [15:0] ah,
                          input logic [15:0] av, input logic vis,
                          input logic flp, input logic [9:0] x,
                          input logic [9:0] y);
      logic [9:0] rsv;
      rsv = 10'($urandom);
      bus.pattern_info = {b, rh, rv, ah, av};
      bus.sprite_info  = {vis, flp, x, y, rsv};
   endtask

   // Drive one raster position, let one edge pass, check the registered result.
   task automatic step(input logic [9:0] h, input logic [9:0] v,
                       input logic chk_addr, input string tag);
      logic        ev;
      logic [15:0] ea;
      bus.hcount = h;
      bus.vcount = v;
      model(bus.pattern_info, bus.sprite_info, h, v, reset, ev, ea);
      @(posedge clk);
      #1;
      tests++;
      assert (bus.valid === ev) else begin
         fails++;
         $error("FAIL %s valid: got %0b expected %0b (h=%0d v=%0d)", tag, bus.valid, ev, h, v);
      end
      if (chk_addr) begin
         tests++;
         assert (bus.addr_output === ea) else begin
            fails++;
            $error("FAIL %s addr: got 0x%04h expected 0x%04h (h=%0d v=%0d)", tag, bus.addr_output, ea, h, v);
         end
      end
   endtask

   task automatic check_const(input logic ev, input logic [15:0] ea, input string tag);
      tests++;
      assert (bus.valid === ev && bus.addr_output === ea) else begin
         fails++;
         $error("FAIL %s: got valid=%0b addr=0x%04h expected valid=%0b addr=0x%04h", tag, bus.valid, bus.addr_output, ev, ea);
      end
   endtask

   initial begin
      logic [15:0] rh, rv, ah, av;
      logic [9:0]  x, y, h, v;
      reset      = 1'b1;
      bus.hcount = 10'd0;
      bus.vcount = 10'd0;
      set_cfg(16'h0000, 16'd64, 16'd64, 16'd64, 16'd64, 1'b1, 1'b0, 10'd100, 10'd50);

      step(10'd100, 10'd50, 1'b1, "reset_hold");
      check_const(1'b0, 16'd0, "reset_hold_const");
      reset = 1'b0;
      step(10'd163, 10'd113, 1'b1, "after_reset");
      check_const(1'b1, 16'd4095, "after_reset_const");

      step(10'd100, 10'd50, 1'b1, "corner_tl");
      check_const(1'b1, 16'd0, "corner_tl_const");
      step(10'd163, 10'd113, 1'b1, "corner_br");
      step(10'd164, 10'd50, 1'b1, "right_out");
      check_const(1'b0, 16'd0, "right_out_const");
      step(10'd100, 10'd114, 1'b1, "below_out");
      step(10'd99, 10'd50, 1'b1, "left_out");

      set_cfg(16'h0000, 16'd64, 16'd64, 16'd64, 16'd64, 1'b1, 1'b1, 10'd100, 10'd50);
      step(10'd100, 10'd50, 1'b1, "flip_tl");
      check_const(1'b1, 16'd63, "flip_tl_const");
      step(10'd163, 10'd51, 1'b1, "flip_r");
      check_const(1'b1, 16'd64, "flip_r_const");

      set_cfg(16'h1000, 16'd64, 16'd64, 16'd128, 16'd64, 1'b1, 1'b0, 10'd100, 10'd50);
      step(10'd170, 10'd51, 1'b1, "tile_base");
      check_const(1'b1, 16'h1046, "tile_base_const");

      set_cfg(16'h0000, 16'd64, 16'd64, 16'd64, 16'd64, 1'b0, 1'b0, 10'd100, 10'd50);
      step(10'd100, 10'd50, 1'b1, "invisible");
      set_cfg(16'h0000, 16'd64, 16'd64, 16'd0, 16'd64, 1'b1, 1'b0, 10'd100, 10'd50);
      step(10'd100, 10'd50, 1'b1, "acth_zero");

      set_cfg(16'h0000, 16'd64, 16'd64, 16'd64, 16'd64, 1'b1, 1'b0, 10'd1000, 10'd0);
      step(10'd1023, 10'd0, 1'b1, "clip_edge");
      check_const(1'b1, 16'd23, "clip_edge_const");
      step(10'd5, 10'd0, 1'b1, "no_wrap_lo");
      step(10'd999, 10'd0, 1'b1, "no_wrap_999");

      set_cfg(16'h0000, 16'd64, 16'd64, 16'd64, 16'd64, 1'b1, 1'b0, 10'd100, 10'd50);
      reset = 1'b1;
      step(10'd110, 10'd60, 1'b1, "midframe_reset");
      reset = 1'b0;
      step(10'd110, 10'd60, 1'b1, "midframe_release");

      set_cfg(16'h0200, 16'd32, 16'd32, 16'd40, 16'd8, 1'b1, 1'b0, 10'd300, 10'd60);
      for (int i = 0; i < 1024; i++) step(10'(i), 10'd61, 1'b1, "sweep");

      for (int i = 0; i < 400; i++) begin
         rh = 16'd1 << $urandom_range(0, 15);
         rv = 16'd1 << $urandom_range(0, 15);
         ah = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
         av = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
         x  = 10'($urandom);
         y  = 10'($urandom);
         h  = 10'(x + 10'($urandom_range(0, 350)));
         v  = 10'(y + 10'($urandom_range(0, 350)));
         set_cfg(16'($urandom), rh, rv, ah, av, ($urandom_range(0, 7) != 0),
                 1'($urandom), x, y);
         step(h, v, 1'b1, "random");
      end

      for (int i = 0; i < 50; i++) begin
         x = 10'($urandom);
         y = 10'($urandom);
         set_cfg(16'($urandom), 16'($urandom_range(1, 100)), 16'($urandom_range(1, 100)),
                 16'($urandom_range(0, 200)), 16'($urandom_range(0, 200)),
                 1'b1, 1'($urandom), x, y);
         step(10'(x + 10'($urandom_range(0, 250))), 10'(y + 10'($urandom_range(0, 250))),
              1'b0, "npot_valid");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
